// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined), LSB first.
// Latency: 2-clk synchroniser; byte appears mid stop bit (~9.5 bit times after start edge).
// Backpressure: valid/data held until ready; a byte completing while held is dropped and sets sticky overrun.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_DIV = (CLK_FREQ + UART_BPS / 2) / UART_BPS;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic            bit_done;
  logic            par_ok;

`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_ok = ~(^{shift_q, par_q});
`else
  assign par_ok = 1'b1;
`endif

  assign bit_done  = (bcnt_q == BIT_END);
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // Next-state logic: frame sequencing, bit sampling and consumer handshake.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q + 1'b1;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~ready;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        // Edge-triggered so a held break cannot restart a frame.
        if (rxd_prev_q && !rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (bcnt_q == HALF_END) begin
          bcnt_d  = '0;
          bidx_d  = 3'd0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          bcnt_d  = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bidx_q == 3'd7) state_d = S_PARITY;
`else
          if (bidx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          bcnt_d  = '0;
          par_d   = rxd_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          // Leave mid stop bit so the next start edge is never missed.
          bcnt_d  = '0;
          state_d = S_IDLE;
          if (rxd_s_q && par_ok) begin
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // State registers and input synchroniser; line flops reset to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      bidx_q      <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= uart_rxd;
      rxd_s_q     <= rxd_meta_q;
      rxd_prev_q  <= rxd_s_q;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule
